dht11_responder: RTL

DHT11_RESPONDER -- requirements
Module: dht11_responder

---
 rtl/dht11_pkg.sv | 53 +++++
 rtl/usec_tick.sv | 33 +++
 rtl/dht11_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: bus phase timings, FSM state encoding and frame helpers.
// The host-side controller imports the same package so both ends agree on timing.
package dht11_pkg;

  // Width of the microsecond counter; wide enough to measure an 18 ms host start.
  localparam int US_CNT_W = 15;
  typedef logic [US_CNT_W-1:0] usCount_t;

  // Saturation value of the microsecond counter.
  localparam usCount_t US_MAX = '1;

  // Phase durations in microseconds, measured from state entry.
  localparam usCount_t T_RESP_DELAY_US = 15'd30;
  localparam usCount_t T_RESP_LOW_US   = 15'd80;
  localparam usCount_t T_RESP_HIGH_US  = 15'd80;
  localparam usCount_t T_BIT_LOW_US    = 15'd50;
  localparam usCount_t T_BIT0_HIGH_US  = 15'd27;
  localparam usCount_t T_BIT1_HIGH_US  = 15'd70;
  localparam usCount_t T_END_LOW_US    = 15'd50;

  // Index of the first bit on the wire; the frame goes out MSB first.
  localparam logic [5:0] LAST_BIT_IDX = 6'd39;

  // Responder state encoding.
  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } dht11State_t;

  // Mod-256 sum of the four data bytes (the two decimal bytes are always zero),
  // optionally inverted so a host can be tested against a corrupt frame.
  function automatic logic [7:0] calcChecksum(input logic [7:0] hum,
                                              input logic [7:0] temp,
                                              input logic       invert);
    logic [7:0] sum;
    sum = hum + temp;
    return invert ? ~sum : sum;
  endfunction

  // Assemble the 40-bit frame exactly as it appears on the wire.
  function automatic logic [39:0] buildFrame(input logic [7:0] hum,
                                             input logic [7:0] temp,
                                             input logic       invert);
    return {hum, 8'h00, temp, 8'h00, calcChecksum(hum, temp, invert)};
  endfunction

endpackage

// File: rtl/usec_tick.sv
// Free-running prescaler producing a one-cycle pulse every CLK_FREQ_MHZ clocks,
// i.e. once per microsecond. All responder timing is counted in these ticks.
module usec_tick #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int CW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_MHZ - 1);

  logic [CW-1:0] r_count;
  logic          r_tick;

  // Count clocks and emit a registered tick when the count wraps.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == LAST) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + 1'b1;
      r_tick  <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a long host start pulse on the single-wire bus,
// answers with the 30/80/80 us response and then shifts out a 40-bit frame
// {humidity, 0, temperature, 0, checksum}, MSB first, using open-drain signalling.
module dht11_responder #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int MIN_START_US = 18000
) (
  input  logic       clk,
  input  logic       reset_p,
  inout  wire        dht11_data,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  input  logic       force_bad_checksum,
  output logic       busy,
  output logic       frame_done
);

  import dht11_pkg::*;

  localparam usCount_t MIN_START = usCount_t'(MIN_START_US);

  dht11State_t r_state;
  usCount_t    r_usCount;
  logic [5:0]  r_bitIdx;
  logic [39:0] r_frame;
  logic        r_pullLow;
  logic        r_busy;
  logic        r_frameDone;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_syncPrev;

  logic        w_tick;
  logic        w_busFall;
  logic        w_busHigh;
  usCount_t    w_phaseDur;
  logic        w_phaseEnd;

  usec_tick #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_usecTick (
    .clk    (clk),
    .reset_p(reset_p),
    .tick   (w_tick)
  );

  // Bring the asynchronous bus into the clock domain; reset to the idle (pulled-up) level
  // so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
    end else begin
      r_sync1    <= dht11_data;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign w_busFall = r_syncPrev & ~r_sync2;
  assign w_busHigh = r_sync2;

  // Select how long the current timed phase lasts; the bit-high phase depends on the bit value.
  always_comb begin
    w_phaseDur = T_RESP_DELAY_US;
    case (r_state)
      RESP_DELAY: w_phaseDur = T_RESP_DELAY_US;
      RESP_LOW:   w_phaseDur = T_RESP_LOW_US;
      RESP_HIGH:  w_phaseDur = T_RESP_HIGH_US;
      BIT_LOW:    w_phaseDur = T_BIT_LOW_US;
      BIT_HIGH:   w_phaseDur = r_frame[r_bitIdx] ? T_BIT1_HIGH_US : T_BIT0_HIGH_US;
      END_LOW:    w_phaseDur = T_END_LOW_US;
      default:    w_phaseDur = T_RESP_DELAY_US;
    endcase
  end

  assign w_phaseEnd = (r_usCount == (w_phaseDur - 15'd1));

  // Main sequencer: start detection, response preamble, bit transmission and frame end.
  // Bus edges are only looked at in IDLE and HOST_LOW, so our own pulls are never mistaken
  // for a new request.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state     <= IDLE;
      r_usCount   <= '0;
      r_bitIdx    <= '0;
      r_frame     <= '0;
      r_pullLow   <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_busFall) begin
            r_state   <= HOST_LOW;
            r_usCount <= '0;
          end
        end
        HOST_LOW: begin
          if (w_busHigh) begin
            r_usCount <= '0;
            if (r_usCount >= MIN_START) begin
              r_state <= RESP_DELAY;
              r_frame <= buildFrame(humidity, temperature, force_bad_checksum);
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_tick && (r_usCount != US_MAX)) begin
            r_usCount <= r_usCount + 15'd1;
          end
        end
        default: begin
          if (w_tick) begin
            if (w_phaseEnd) begin
              r_usCount <= '0;
              case (r_state)
                RESP_DELAY: begin
                  r_state   <= RESP_LOW;
                  r_pullLow <= 1'b1;
                end
                RESP_LOW: begin
                  r_state   <= RESP_HIGH;
                  r_pullLow <= 1'b0;
                end
                RESP_HIGH: begin
                  r_state   <= BIT_LOW;
                  r_pullLow <= 1'b1;
                  r_bitIdx  <= LAST_BIT_IDX;
                end
                BIT_LOW: begin
                  r_state   <= BIT_HIGH;
                  r_pullLow <= 1'b0;
                end
                BIT_HIGH: begin
                  r_state   <= (r_bitIdx == 6'd0) ? END_LOW : BIT_LOW;
                  r_pullLow <= 1'b1;
                  if (r_bitIdx != 6'd0) begin
                    r_bitIdx <= r_bitIdx - 6'd1;
                  end
                end
                END_LOW: begin
                  r_state     <= IDLE;
                  r_pullLow   <= 1'b0;
                  r_busy      <= 1'b0;
                  r_frameDone <= 1'b1;
                end
                default: begin
                  r_state   <= IDLE;
                  r_pullLow <= 1'b0;
                  r_busy    <= 1'b0;
                end
              endcase
            end else begin
              r_usCount <= r_usCount + 15'd1;
            end
          end
        end
      endcase
    end
  end

  // Open-drain driver: we only ever pull low, the external pull-up provides the high level.
  assign dht11_data = r_pullLow ? 1'b0 : 1'bz;

  assign busy       = r_busy;
  assign frame_done = r_frameDone;

endmodule
